parity_checker: RTL and testbench

- Receive end of the 8-bit even-parity link. Accepts 9-bit words {parity, data[7:0]} from the generator side over a valid/ready stream.
- Checks each word, forwards the data with a per-word error flag through one registered output stage, and keeps error statistics.
- Locks the input when too many consecutive bad words arrive, until software clears it.
- Sits between the parity link and the downstream byte consumer.

---
 rtl/parity_checker_if.sv | 25 ++
 rtl/parity_checker.sv | 121 ++++++++++++
 tb/tb_parity_checker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/parity_checker_if.sv
// Stream bundle for the parity checker.
//   in_word/in_valid/in_ready    : 9-bit {parity, data} input stream
//   out_data/out_err/out_valid/out_ready : checked byte output stream
// Modports:
//   slave  - the checker (consumes in_*, produces out_*)
//   master - the surrounding link side (produces in_*, consumes out_*)
interface parity_checker_if;
  logic [8:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/parity_checker.sv
// Receive end of the 8-bit even-parity link. Checks each accepted {parity, data} word,
// forwards the byte with an error flag through one output register, keeps error statistics
// and locks the input after LOCK_THRESH consecutive bad words until clr.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active high
//   bus        - parity_checker_if.slave: input stream and output stream
//   clr        - one-cycle pulse: clear statistics, leave LOCK
//   err_sticky - a bad word was accepted since the last reset/clr
//   err_cnt    - saturating count of accepted bad words
//   locked     - input is locked
//
// Build option: define PARITY_DROP_BAD_EN to drop bad words instead of forwarding them
// (they are still counted and can still cause LOCK; out_err is then tied low).
module parity_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  parity_checker_if.slave  bus,
  input  logic             clr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked
);

  localparam int unsigned ConsW = (LOCK_THRESH == 0) ? 1 : $clog2(LOCK_THRESH + 1);
  localparam logic [ConsW-1:0] ConsMax = ConsW'(LOCK_THRESH);

  typedef enum logic [0:0] {StRun, StLock} state_e;

  state_e           state_q, state_d;
  logic [ConsW-1:0] cons_q, cons_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;

  logic accept;
  logic bad;
  logic load;

  // Depends only on registered state and out_ready, never on in_valid.
  assign bus.in_ready = (state_q == StRun) & (~valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bad          = ^bus.in_word;

`ifdef PARITY_DROP_BAD_EN
  assign load        = accept & ~bad;
  assign bus.out_err = 1'b0;
`else
  assign load        = accept;
  assign bus.out_err = err_q;
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign err_sticky    = sticky_q;
  assign err_cnt       = cnt_q;
  assign locked        = (state_q == StLock);

  always_comb begin
    state_d  = state_q;
    cons_d   = cons_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    valid_d  = valid_q;
    data_d   = data_q;
    err_d    = err_q;

    // Output register: load wins over drain so a transfer and accept can share a cycle.
    if (load) begin
      valid_d = 1'b1;
      data_d  = bus.in_word[7:0];
      err_d   = bad;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    // clr overrides any same-cycle accept for statistics and FSM.
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
      cons_d   = '0;
      state_d  = StRun;
    end else if (accept) begin
      if (bad) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        sticky_d = 1'b1;
        if (cons_q != ConsMax) cons_d = cons_q + 1'b1;
        if ((LOCK_THRESH != 0) && (cons_d == ConsMax)) state_d = StLock;
      end else begin
        cons_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      cons_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cons_q   <= cons_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_parity_checker.sv
module tb_parity_checker;

  logic clk;
  logic rst;
  logic clr_a;
  logic clr_b;

  logic       sticky_a, locked_a;
  logic [7:0] cnt_a;
  logic       sticky_b, locked_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  parity_checker_if bus_a ();
  parity_checker_if bus_b ();

  parity_checker #(.CNT_W(8), .LOCK_THRESH(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a),
    .clr        (clr_a),
    .err_sticky (sticky_a),
    .err_cnt    (cnt_a),
    .locked     (locked_a)
  );

  parity_checker #(.CNT_W(2), .LOCK_THRESH(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b),
    .clr        (clr_b),
    .err_sticky (sticky_b),
    .err_cnt    (cnt_b),
    .locked     (locked_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [8:0] word;
    logic       vld;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_err;
    logic       e_sticky;
    logic [7:0] e_cnt;
    logic       e_lock;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic [8:0] w, logic v, logic o, logic er,
                              logic ev, logic [7:0] ed, logic ee, logic es, logic [7:0] ec,
                              logic el);
    vec_t t;
    t.rst = r; t.clr = c; t.word = w; t.vld = v; t.ordy = o;
    t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.e_err = ee;
    t.e_sticky = es; t.e_cnt = ec; t.e_lock = el;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input int idx, input vec_t t);
    @(negedge clk);
    rst                = t.rst;
    clr_a              = t.clr;
    bus_a.in_word      = t.word;
    bus_a.in_valid     = t.vld;
    bus_a.out_ready    = t.ordy;
    #1;
    chk($sformatf("v%0d in_ready", idx), {31'd0, bus_a.in_ready}, {31'd0, t.e_rdy});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), {31'd0, bus_a.out_valid}, {31'd0, t.e_vld});
    chk($sformatf("v%0d out_data", idx), {24'd0, bus_a.out_data}, {24'd0, t.e_data});
    chk($sformatf("v%0d out_err", idx), {31'd0, bus_a.out_err}, {31'd0, t.e_err});
    chk($sformatf("v%0d err_sticky", idx), {31'd0, sticky_a}, {31'd0, t.e_sticky});
    chk($sformatf("v%0d err_cnt", idx), {24'd0, cnt_a}, {24'd0, t.e_cnt});
    chk($sformatf("v%0d locked", idx), {31'd0, locked_a}, {31'd0, t.e_lock});
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.in_word = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_word = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;

    //         rst clr word    v  or   rdy vld data  err stk cnt    lck
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 1,  1, 1, 8'hAA, 0, 0, 8'd0, 0)); // good word
    vecs.push_back(mk(0, 0, 9'h1AA, 1, 1,  1, 1, 8'hAA, 1, 1, 8'd1, 0)); // bad parity
    vecs.push_back(mk(0, 0, 9'h1AB, 1, 1,  1, 1, 8'hAB, 0, 1, 8'd1, 0)); // good, odd data
    vecs.push_back(mk(0, 0, 9'h08C, 1, 1,  1, 1, 8'h8C, 1, 1, 8'd2, 0)); // 8C has odd weight
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 0,  0, 1, 8'h8C, 1, 1, 8'd2, 0)); // stalled: hold
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 1,  1, 1, 8'hAA, 0, 1, 8'd2, 0)); // transfer + accept
    vecs.push_back(mk(0, 0, 9'h000, 0, 1,  1, 0, 8'hAA, 0, 1, 8'd2, 0)); // drain
    vecs.push_back(mk(0, 0, 9'h1AA, 1, 1,  1, 1, 8'hAA, 1, 1, 8'd3, 0)); // bad 1
    vecs.push_back(mk(0, 0, 9'h001, 1, 1,  1, 1, 8'h01, 1, 1, 8'd4, 0)); // bad 2
    vecs.push_back(mk(0, 0, 9'h1FF, 1, 1,  1, 1, 8'hFF, 1, 1, 8'd5, 0)); // bad 3
    vecs.push_back(mk(0, 0, 9'h080, 1, 1,  1, 1, 8'h80, 1, 1, 8'd6, 1)); // bad 4 -> lock
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 0,  0, 1, 8'h80, 1, 1, 8'd6, 1)); // locked, held
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 1,  0, 0, 8'h80, 1, 1, 8'd6, 1)); // drains in lock
    vecs.push_back(mk(0, 1, 9'h000, 0, 1,  0, 0, 8'h80, 1, 0, 8'd0, 0)); // clr unlocks
    vecs.push_back(mk(0, 0, 9'h0AA, 1, 1,  1, 1, 8'hAA, 0, 0, 8'd0, 0)); // accepting again
    vecs.push_back(mk(0, 0, 9'h1AA, 1, 1,  1, 1, 8'hAA, 1, 1, 8'd1, 0)); // bad 1
    vecs.push_back(mk(0, 0, 9'h001, 1, 1,  1, 1, 8'h01, 1, 1, 8'd2, 0)); // bad 2
    vecs.push_back(mk(0, 0, 9'h1FF, 1, 1,  1, 1, 8'hFF, 1, 1, 8'd3, 0)); // bad 3
    vecs.push_back(mk(0, 1, 9'h080, 1, 1,  1, 1, 8'h80, 1, 0, 8'd0, 0)); // clr beats bad 4
    vecs.push_back(mk(0, 0, 9'h1AA, 1, 1,  1, 1, 8'hAA, 1, 1, 8'd1, 0)); // run of 1 only
    vecs.push_back(mk(1, 0, 9'h000, 0, 0,  0, 0, 8'h00, 0, 0, 8'd0, 0)); // rst drops word
    vecs.push_back(mk(0, 0, 9'h000, 0, 1,  1, 0, 8'h00, 0, 0, 8'd0, 0)); // idle after rst

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    chk("reset out_data", {24'd0, bus_a.out_data}, 32'd0);
    chk("reset out_err", {31'd0, bus_a.out_err}, 32'd0);
    chk("reset err_sticky", {31'd0, sticky_a}, 32'd0);
    chk("reset err_cnt", {24'd0, cnt_a}, 32'd0);
    chk("reset locked", {31'd0, locked_a}, 32'd0);
    chk("reset b err_cnt", {30'd0, cnt_b}, 32'd0);

    // Narrow counter, locking disabled: count saturates at 3 and never locks.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_b.in_word   = 9'h1AA;
      bus_b.in_valid  = 1'b1;
      bus_b.out_ready = 1'b1;
      #1;
      chk($sformatf("b%0d in_ready", i), {31'd0, bus_b.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b%0d err_cnt", i), {30'd0, cnt_b}, (i < 3) ? i + 1 : 3);
      chk($sformatf("b%0d locked", i), {31'd0, locked_b}, 32'd0);
      chk($sformatf("b%0d out_err", i), {31'd0, bus_b.out_err}, 32'd1);
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(i, vecs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
